// File: rtl/router_arb_pkg.sv
// Shared types and helpers for the router output/VC schedulers.
package router_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Increment with wrap modulo n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Rotate-priority encoder: first set bit of eligible at or after rr_ptr, wrapping.
module rr_priority_picker #(
  parameter int unsigned N  = 5,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] rr_ptr,
  output logic          found,
  output logic [IW-1:0] winner,
  output logic [N-1:0]  onehot
);

  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    winner = '0;
    onehot = '0;
    idx    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && eligible[idx]) begin
        found       = 1'b1;
        winner      = IW'(idx);
        onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_output_arbiter.sv
// Per-output scheduler: round-robin packet arbitration, wormhole lock, credit flow control.
module router_output_arbiter
  import router_arb_pkg::*;
#(
  parameter int unsigned NUM_INPUTS        = 5,
  parameter int unsigned FLIT_BUFFER_DEPTH = 4,
  parameter int unsigned IDX_WIDTH         = $clog2(NUM_INPUTS),
  parameter int unsigned CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                    clk_noc,
  input  logic                    rst_noc,
  input  logic [NUM_INPUTS-1:0]   req,
  input  logic [NUM_INPUTS-1:0]   req_is_tail,
  input  logic [NUM_INPUTS-1:0]   disable_turn,
  input  logic                    credit_in,
  output logic [NUM_INPUTS-1:0]   grant,
  output logic                    grant_valid,
  output logic [IDX_WIDTH-1:0]    grant_idx,
  output logic                    locked,
  output logic [IDX_WIDTH-1:0]    lock_owner,
  output logic [CREDIT_WIDTH-1:0] credit_count,
  output logic                    credit_err
);

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

  arb_state_e                state_q, state_d;
  logic [IDX_WIDTH-1:0]      owner_q, owner_d;
  logic [IDX_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CREDIT_WIDTH-1:0]   credit_q, credit_d;
  logic                      err_q, err_d;

  logic [NUM_INPUTS-1:0]     eligible;
  logic                      pick_found;
  logic [IDX_WIDTH-1:0]      pick_idx;
  logic [NUM_INPUTS-1:0]     pick_onehot;
  logic                      credits_ok;

  assign eligible   = req & ~disable_turn;
  assign credits_ok = (credit_q != '0);

  rr_priority_picker #(
    .N  (NUM_INPUTS),
    .IW (IDX_WIDTH)
  ) u_picker (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .found    (pick_found),
    .winner   (pick_idx),
    .onehot   (pick_onehot)
  );

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found && credits_ok) begin
          grant       = pick_onehot;
          grant_valid = 1'b1;
          grant_idx   = pick_idx;
          if (req_is_tail[pick_idx]) begin
            rr_ptr_d = IDX_WIDTH'(rr_next(int'(pick_idx), NUM_INPUTS));
          end else begin
            state_d = LOCKED;
            owner_d = pick_idx;
          end
        end
      end
      LOCKED: begin
        // The owner's turn restriction was already honoured when its head flit won.
        if (req[owner_q] && credits_ok) begin
          grant[owner_q] = 1'b1;
          grant_valid    = 1'b1;
          grant_idx      = owner_q;
          if (req_is_tail[owner_q]) begin
            state_d  = IDLE;
            owner_d  = '0;
            rr_ptr_d = IDX_WIDTH'(rr_next(int'(owner_q), NUM_INPUTS));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (grant_valid && !credit_in) begin
      credit_d = credit_q - 1'b1;
    end else if (!grant_valid && credit_in) begin
      if (credit_q == CREDIT_MAX) err_d = 1'b1;
      else                        credit_d = credit_q + 1'b1;
    end
  end

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      credit_q <= CREDIT_MAX;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign locked       = (state_q == LOCKED);
  assign lock_owner   = locked ? owner_q : '0;
  assign credit_count = credit_q;
  assign credit_err   = err_q;

endmodule

// File: doc/router_output_arbiter.md
Name: router_output_arbiter

Overview:
- Per-output-port scheduler for the NoC router. Shares one router output port among the NUM_INPUTS input buffers, which are the local injection port plus the N/S/E/W ports.
- Uses round-robin packet arbitration with wormhole locking: once a head flit wins, the output stays with that input until its tail flit passes.
- Tracks downstream buffer credits for the link, so a flit is forwarded only when the downstream FIFO has space.
- Honors the DISABLE_TURNS column for this output. The router instantiates one arbiter per output; the grant drives that output's crossbar mux and that input's FIFO pop.

Parameters:
- NUM_INPUTS, 5, number of requesting input ports (index 0 = local injection).
- FLIT_BUFFER_DEPTH, 4, downstream flit buffer depth; initial and maximum credit count.
- IDX_WIDTH, $clog2(NUM_INPUTS), width of the input index.
- CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width.

Ports:
- clk_noc  in  1  NoC clock.
- rst_noc  in  1  reset, asynchronous, active-high.
- req  in  NUM_INPUTS  input i has a valid flit routed to this output.
- req_is_tail  in  NUM_INPUTS  flit at input i is a tail flit.
- disable_turn  in  NUM_INPUTS  1 = turn from input i to this output is prohibited.
- credit_in  in  1  one-cycle pulse: downstream freed one buffer slot.
- grant  out  NUM_INPUTS  one-hot (or zero); input i's flit is forwarded and popped this cycle.
- grant_valid  out  1  OR of grant; drives send_out for this link.
- grant_idx  out  IDX_WIDTH  index of the granted input (0 when grant_valid=0).
- locked  out  1  a multi-flit packet currently owns the output.
- lock_owner  out  IDX_WIDTH  owning input while locked, else 0.
- credit_count  out  CREDIT_WIDTH  current credit count.
- credit_err  out  1  sticky: credit_in received while count == FLIT_BUFFER_DEPTH.

Behaviour:
- Registered state: fsm (IDLE/LOCKED), lock_owner, rr_ptr, credit_count, credit_err.
- grant, grant_valid and grant_idx are combinational from registered state and the current req, req_is_tail and disable_turn. Latency from req to grant is zero cycles; from grant to state update is one cycle.
- Reset values (asynchronous, immediate):
  - fsm=IDLE, lock_owner=0, rr_ptr=0.
  - credit_count=FLIT_BUFFER_DEPTH, credit_err=0.
  - Outputs: grant=0, locked=0.
- Eligibility: eligible = req & ~disable_turn. No grant is issued when credit_count==0. A credit_in arriving in the same cycle does not enable a grant that cycle.
- IDLE state:
  - Winner is the first eligible index searching rr_ptr, rr_ptr+1, … with wrap modulo NUM_INPUTS.
  - If the winner's req_is_tail=1 (single-flit packet): stay IDLE, rr_ptr ← winner+1 (wraps to 0 after NUM_INPUTS-1).
  - Else: go to LOCKED, lock_owner ← winner, rr_ptr unchanged.
- LOCKED state:
  - Grant only lock_owner, when req[lock_owner]=1 and credits>0. disable_turn is ignored for the owner.
  - Other requests are never granted. A bubble (req[owner]=0) holds the lock.
  - Granted flit with req_is_tail=1: go to IDLE, rr_ptr ← owner+1 mod NUM_INPUTS.
- Credit arithmetic: next = credit_count − grant_valid + credit_in.
  - Simultaneous grant and credit_in leaves the count unchanged.
  - credit_in at count==FLIT_BUFFER_DEPTH with no grant: count saturates and credit_err sets. It clears only on reset.
  - Underflow cannot occur, because no grant is issued at count 0.
- grant is always one-hot or zero. A grant is never issued to an input with req=0.
- Reset mid-packet abandons the lock. The upstream is reset by the same reset tree.

Decomposition:
- Package router_arb_pkg holds:
  - arb_state_e (IDLE, LOCKED), a 1-bit enum.
  - Function rr_next(idx, n), which returns idx+1 wrapped modulo n.
- Sub-module rr_priority_picker: purely combinational rotate-priority encoder.
  - Inputs: eligible vector, rr_ptr.
  - Outputs: found, winner index, one-hot.
  - Reusable by the VC/local-port schedulers.

Test Plan:
- Default parameters (NUM_INPUTS=5, FLIT_BUFFER_DEPTH=4), credit_in tied 1 except in the credit-exhaustion scenario.
- Reset release: no requests → grant=0, locked=0, credit_count=4, credit_err=0.
- Single-flit round robin: req[1]=req[3]=1, all tails, held → grants 1,3,1,3 on consecutive cycles; locked stays 0.
- Wormhole lock: input 2 sends a 3-flit packet (tail on 3rd) while req[4]=1 continuously → grants 2,2,2,4. locked=1 with lock_owner=2 during the cycles of the 2nd and 3rd flits.
- Credit exhaustion: credit_in=0, input 0 offers a 6-flit packet → 4 grants, then grant=0 with req[0]=1 and credit_count=0. One credit_in pulse → exactly one grant on the following cycle.
- Disabled turn: disable_turn[0]=1, only req[0]=1 → no grant for 10 cycles. Clear disable_turn[0] → grant[0] the same cycle.
- Reset and overflow: assert rst_noc after 2 flits of a locked packet → locked=0 and credit_count=4 without a clock edge. Then pulse credit_in with no traffic → credit_err=1, credit_count stays 4.
